// File: rtl/ls_ctrl_pkg.sv
// Shared definitions for the front-panel scan control: debouncer states,
// quadrature transition codes and default parameter values.
package ls_ctrl_pkg;

  typedef enum logic [1:0] {
    RELEASED   = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } deb_state_t;

  localparam int DEF_DEB_CYC    = 50000;
  localparam int DEF_REP_DLY    = 25000000;
  localparam int DEF_REP_PER    = 5000000;
  localparam int DEF_CURS_MIN   = 5;
  localparam int DEF_CURS_MAX   = 639;
  localparam int DEF_CURS_INIT  = 320;
  localparam int DEF_CURS_STEP  = 1;
  localparam int DEF_SCAN_MAX   = 15;
  localparam int DEF_SCAN_INIT  = 8;
  localparam int DEF_SCAN_N_MAX = 255;

  // {previous AB, current AB}; forward Gray order is 00 -> 01 -> 11 -> 10 -> 00
  localparam logic [3:0] QF_00_01 = 4'b0001;
  localparam logic [3:0] QF_01_11 = 4'b0111;
  localparam logic [3:0] QF_11_10 = 4'b1110;
  localparam logic [3:0] QF_10_00 = 4'b1000;
  localparam logic [3:0] QR_00_10 = 4'b0010;
  localparam logic [3:0] QR_10_11 = 4'b1011;
  localparam logic [3:0] QR_11_01 = 4'b1101;
  localparam logic [3:0] QR_01_00 = 4'b0100;

  // +1 forward, -1 reverse, 0 for no change or an illegal double-bit jump
  function automatic logic signed [1:0] quad_dir(input logic [1:0] prev, input logic [1:0] curr);
    case ({prev, curr})
      QF_00_01, QF_01_11, QF_11_10, QF_10_00: return 2'sd1;
      QR_00_10, QR_10_11, QR_11_01, QR_01_00: return -2'sd1;
      default:                                return 2'sd0;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, debounce FSM and auto-repeat
// timer. evt pulses for one clock on a debounced press and on each repeat.
module btn_debounce
  import ls_ctrl_pkg::*;
#(
  parameter int DEB_CYC = DEF_DEB_CYC,
  parameter int REP_DLY = DEF_REP_DLY,
  parameter int REP_PER = DEF_REP_PER
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic evt
);

  localparam int DW = $clog2(DEB_CYC + 1);
  localparam int RW = $clog2(((REP_DLY > REP_PER) ? REP_DLY : REP_PER) + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REP_DLY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REP_PER - 1);

  logic [1:0]    sync;
  logic          level;
  deb_state_t    state;
  logic [DW-1:0] cnt;
  logic [RW-1:0] rep_cnt;
  logic          rep_first;

  assign level = sync[1];

  // Two-stage synchroniser; resets to the released (high) level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], btn};
  end

  // Debounce FSM with repeat timer; the timer only advances while HELD and
  // keeps its count through REL_WAIT so a bounce on release does not restart it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RELEASED;
      cnt       <= '0;
      rep_cnt   <= '0;
      rep_first <= 1'b1;
      evt       <= 1'b0;
    end else begin
      evt <= 1'b0;
      case (state)
        RELEASED: begin
          if (!level) begin
            state <= PRESS_WAIT;
            cnt   <= DW'(1);
          end
        end
        PRESS_WAIT: begin
          if (level) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state     <= HELD;
            cnt       <= '0;
            rep_cnt   <= '0;
            rep_first <= 1'b1;
            evt       <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (level) begin
            state <= REL_WAIT;
            cnt   <= DW'(1);
          end else if (rep_cnt == (rep_first ? DLY_LAST : PER_LAST)) begin
            rep_cnt   <= '0;
            rep_first <= 1'b0;
            evt       <= 1'b1;
          end else begin
            rep_cnt <= rep_cnt + 1'b1;
          end
        end
        REL_WAIT: begin
          // A low sample here is release bounce, not a new press: no event
          if (!level) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state <= RELEASED;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RELEASED;
      endcase
    end
  end

endmodule

// File: rtl/scan_control.sv
// Front-panel input stage: decodes the rotary encoder into cursor moves and
// turns zoom/scroll button events into saturating timebase/page updates.
module scan_control
  import ls_ctrl_pkg::*;
#(
  parameter int DEB_CYC    = DEF_DEB_CYC,
  parameter int REP_DLY    = DEF_REP_DLY,
  parameter int REP_PER    = DEF_REP_PER,
  parameter int CURS_MIN   = DEF_CURS_MIN,
  parameter int CURS_MAX   = DEF_CURS_MAX,
  parameter int CURS_INIT  = DEF_CURS_INIT,
  parameter int CURS_STEP  = DEF_CURS_STEP,
  parameter int SCAN_MAX   = DEF_SCAN_MAX,
  parameter int SCAN_INIT  = DEF_SCAN_INIT,
  parameter int SCAN_N_MAX = DEF_SCAN_N_MAX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enc_a,
  input  logic       enc_b,
  input  logic       btn_zin,
  input  logic       btn_zout,
  input  logic       btn_scl,
  input  logic       btn_scr,
  output logic [9:0] curs_data,
  output logic [3:0] scan_data,
  output logic [7:0] scan_n,
  output logic       cfg_chg
);

  logic zin_evt, zout_evt, scl_evt, scr_evt;

  btn_debounce #(.DEB_CYC(DEB_CYC), .REP_DLY(REP_DLY), .REP_PER(REP_PER))
    u_zin  (.clk(clk), .rst_n(rst_n), .btn(btn_zin),  .evt(zin_evt));
  btn_debounce #(.DEB_CYC(DEB_CYC), .REP_DLY(REP_DLY), .REP_PER(REP_PER))
    u_zout (.clk(clk), .rst_n(rst_n), .btn(btn_zout), .evt(zout_evt));
  btn_debounce #(.DEB_CYC(DEB_CYC), .REP_DLY(REP_DLY), .REP_PER(REP_PER))
    u_scl  (.clk(clk), .rst_n(rst_n), .btn(btn_scl),  .evt(scl_evt));
  btn_debounce #(.DEB_CYC(DEB_CYC), .REP_DLY(REP_DLY), .REP_PER(REP_PER))
    u_scr  (.clk(clk), .rst_n(rst_n), .btn(btn_scr),  .evt(scr_evt));

  function automatic logic [9:0] curs_sat(input logic [9:0] v, input logic up, input logic dn);
    int t;
    t = int'(v);
    if (up) t = t + CURS_STEP;
    if (dn) t = t - CURS_STEP;
    if (t > CURS_MAX) t = CURS_MAX;
    if (t < CURS_MIN) t = CURS_MIN;
    return 10'(t);
  endfunction

  function automatic logic [3:0] scan_sat(input logic [3:0] v, input logic up, input logic dn);
    if (up && v != 4'(SCAN_MAX)) return v + 4'd1;
    if (dn && v != 4'd0)         return v - 4'd1;
    return v;
  endfunction

  function automatic logic [7:0] page_sat(input logic [7:0] v, input logic up, input logic dn);
    if (up && v != 8'(SCAN_N_MAX)) return v + 8'd1;
    if (dn && v != 8'd0)           return v - 8'd1;
    return v;
  endfunction

  logic [1:0]        a_sync, b_sync, quad, quad_prev;
  logic signed [1:0] dir;
  logic signed [2:0] res, res_nxt;
  logic              det_up, det_dn;
  logic [9:0]        curs_nxt;
  logic [3:0]        scan_nxt;
  logic [7:0]        page_nxt;
  logic              cfg_nxt;

  assign quad = {a_sync[1], b_sync[1]};
  assign dir  = quad_dir(quad_prev, quad);

  // Encoder residue and next-state for all three configuration registers;
  // opposite events in the same cycle cancel before saturation is applied
  always_comb begin
    det_up   = (dir == 2'sd1)  && (res == 3'sd3);
    det_dn   = (dir == -2'sd1) && (res == -3'sd3);
    res_nxt  = (det_up || det_dn) ? 3'sd0 : res + {dir[1], dir};
    curs_nxt = curs_sat(curs_data, det_up, det_dn);
    scan_nxt = scan_sat(scan_data, zin_evt & ~zout_evt, zout_evt & ~zin_evt);
    page_nxt = page_sat(scan_n, scr_evt & ~scl_evt, scl_evt & ~scr_evt);
    cfg_nxt  = (scan_nxt != scan_data) || (page_nxt != scan_n);
  end

  // Encoder synchronisers, quadrature history and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sync    <= 2'b11;
      b_sync    <= 2'b11;
      quad_prev <= 2'b11;
      res       <= 3'sd0;
      curs_data <= 10'(CURS_INIT);
      scan_data <= 4'(SCAN_INIT);
      scan_n    <= 8'd0;
      cfg_chg   <= 1'b0;
    end else begin
      a_sync    <= {a_sync[0], enc_a};
      b_sync    <= {b_sync[0], enc_b};
      quad_prev <= quad;
      res       <= res_nxt;
      curs_data <= curs_nxt;
      scan_data <= scan_nxt;
      scan_n    <= page_nxt;
      cfg_chg   <= cfg_nxt;
    end
  end

endmodule
